// File: rtl/strm_cmd_sequencer_pkg.sv
// Shared types for the stream command sequencer: header layout, engine opcodes,
// sequencer states and the opcode-to-engine decode.
package strm_cmd_sequencer_pkg;

  localparam int NUM_ENG     = 4;
  localparam int OP_PARAMS_W = 28;

  typedef enum logic [3:0] {
    BYPASS         = 4'b0000,
    MOVING_AVERAGE = 4'b0001,
    SIN_FN         = 4'b0010,
    CUSTOM_HLS     = 4'b0100
  } strm_functions;

  typedef struct packed {
    logic [3:0]             op_code;
    logic [OP_PARAMS_W-1:0] op_params;
  } CMD_HEADER;

  typedef enum logic [1:0] {
    SEQ_DECODE,
    SEQ_ACTIVE,
    SEQ_FLUSH,
    SEQ_DRAIN
  } seq_states_t;

  typedef struct packed {
    logic       legal;
    logic [1:0] idx;
  } eng_sel_t;

  function automatic eng_sel_t op_to_eng(input strm_functions op);
    eng_sel_t r;
    r.legal = 1'b1;
    r.idx   = 2'd0;
    case (op)
      BYPASS:         r.idx = 2'd0;
      MOVING_AVERAGE: r.idx = 2'd1;
      SIN_FN:         r.idx = 2'd2;
      CUSTOM_HLS:     r.idx = 2'd3;
      default:        r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/strm_seq_res_mux.sv
// Result mux: forwards the selected engine's result stream to egress and returns
// egress ready to that engine only; zero latency, everything idle when disabled.
module strm_seq_res_mux
  import strm_cmd_sequencer_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic               en,
  input  logic [1:0]         sel,
  input  logic [NUM_ENG*DW-1:0] res_tdata,
  input  logic [NUM_ENG-1:0] res_tvalid,
  input  logic [NUM_ENG-1:0] res_tlast,
  output logic [NUM_ENG-1:0] res_tready,
  output logic [DW-1:0]      m_tdata,
  output logic               m_tvalid,
  output logic               m_tlast,
  input  logic               m_tready,
  output logic               last_hs
);

  always_comb begin
    m_tdata    = res_tdata[sel*DW +: DW];
    m_tvalid   = en & res_tvalid[sel];
    m_tlast    = en & res_tlast[sel];
    res_tready = '0;
    if (en) res_tready[sel] = m_tready;
  end

  assign last_hs = m_tvalid & m_tready & m_tlast;

endmodule

// File: rtl/strm_cmd_sequencer.sv
// Header-driven steering of payload to one of NUM_ENG engines and of its results to egress.
// Zero-latency combinational data paths; ingress stalls follow the selected engine's ready.
module strm_cmd_sequencer
  import strm_cmd_sequencer_pkg::*;
#(
  parameter int DW    = 32,
  parameter int LEN_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DW-1:0]          s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic                   s_tlast,
  output logic [DW-1:0]          eng_tdata,
  output logic [NUM_ENG-1:0]     eng_tvalid,
  input  logic [NUM_ENG-1:0]     eng_tready,
  output logic                   eng_tlast,
  output logic [OP_PARAMS_W-1:0] eng_params,
  input  logic [NUM_ENG*DW-1:0]  res_tdata,
  input  logic [NUM_ENG-1:0]     res_tvalid,
  input  logic [NUM_ENG-1:0]     res_tlast,
  output logic [NUM_ENG-1:0]     res_tready,
  output logic [DW-1:0]          m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic                   busy,
  output logic [3:0]             cur_op,
  output logic                   err_opcode,
  output logic                   err_len,
  output logic [15:0]            cmd_count
);

  seq_states_t      state;
  logic [LEN_W-1:0] rem;
  logic [1:0]       sel;
  logic             res_done;
  logic             ready_en;

  CMD_HEADER        hdr;
  eng_sel_t         dec;
  logic [LEN_W-1:0] hdr_len;
  logic             s_hs;
  logic             rem_one;
  logic             in_last;
  logic             len_bad;
  logic             res_en;
  logic             res_last_hs;

  assign hdr     = s_tdata[31:0];
  assign hdr_len = hdr.op_params[LEN_W-1:0];
  assign dec     = op_to_eng(strm_functions'(hdr.op_code));

  assign s_hs    = s_tvalid & s_tready;
  assign rem_one = (rem == LEN_W'(1));
  assign in_last = s_tlast | rem_one;
  // Either an early tlast or a missing one on the final counted beat.
  assign len_bad = s_tlast ^ rem_one;
  assign res_en  = (state == SEQ_ACTIVE) || (state == SEQ_FLUSH);
  assign busy    = (state != SEQ_DECODE);

  assign eng_tdata = s_tdata;

  always_comb begin
    s_tready   = 1'b0;
    eng_tvalid = '0;
    eng_tlast  = 1'b0;
    case (state)
      SEQ_DECODE: s_tready = ready_en;
      SEQ_ACTIVE: begin
        s_tready        = eng_tready[sel];
        eng_tvalid[sel] = s_tvalid;
        eng_tlast       = in_last;
      end
      SEQ_DRAIN:  s_tready = 1'b1;
      default:    s_tready = 1'b0;
    endcase
  end

  strm_seq_res_mux #(
    .DW(DW)
  ) u_res_mux (
    .en         (res_en),
    .sel        (sel),
    .res_tdata  (res_tdata),
    .res_tvalid (res_tvalid),
    .res_tlast  (res_tlast),
    .res_tready (res_tready),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .last_hs    (res_last_hs)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEQ_DECODE;
      rem        <= '0;
      sel        <= 2'd0;
      res_done   <= 1'b0;
      ready_en   <= 1'b0;
      cur_op     <= 4'd0;
      eng_params <= '0;
      err_opcode <= 1'b0;
      err_len    <= 1'b0;
      cmd_count  <= 16'd0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        SEQ_DECODE: begin
          if (s_hs) begin
            cur_op     <= hdr.op_code;
            eng_params <= hdr.op_params;
            rem        <= hdr_len;
            sel        <= dec.idx;
            res_done   <= 1'b0;
            if (!dec.legal) err_opcode <= 1'b1;
            if (hdr_len == '0) cmd_count <= cmd_count + 16'd1;
            else if (dec.legal) state <= SEQ_ACTIVE;
            else state <= SEQ_DRAIN;
          end
        end
        SEQ_ACTIVE: begin
          if (res_last_hs) res_done <= 1'b1;
          if (s_hs) begin
            rem <= rem - LEN_W'(1);
            if (in_last) begin
              if (len_bad) err_len <= 1'b1;
              // Results may already be complete, possibly on this very edge.
              if (res_done || res_last_hs) begin
                cmd_count <= cmd_count + 16'd1;
                res_done  <= 1'b0;
                state     <= SEQ_DECODE;
              end else begin
                state <= SEQ_FLUSH;
              end
            end
          end
        end
        SEQ_FLUSH: begin
          if (res_done || res_last_hs) begin
            cmd_count <= cmd_count + 16'd1;
            res_done  <= 1'b0;
            state     <= SEQ_DECODE;
          end
        end
        SEQ_DRAIN: begin
          if (s_hs) begin
            rem <= rem - LEN_W'(1);
            if (in_last) begin
              if (len_bad) err_len <= 1'b1;
              cmd_count <= cmd_count + 16'd1;
              state     <= SEQ_DECODE;
            end
          end
        end
        default: state <= SEQ_DECODE;
      endcase
    end
  end

endmodule
